// File: rtl/udp_tx_scheduler.sv
// Round-robin arbiter that shares one UDP frame sender between N_CH channels.
// Optional WAIT_END watchdog is compiled in with `define UDP_SCHED_WATCHDOG_EN.
module udp_tx_scheduler #(
    parameter int N_CH        = 4,
    parameter int GAP_CYCLES  = 12,
    parameter int MAX_LEN     = 1464,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      req,
    input  logic [16*N_CH-1:0]   len_i,
    input  logic [32*N_CH-1:0]   time_i,
    output logic [N_CH-1:0]      grant,
    output logic [N_CH-1:0]      done,
    output logic                 reject,
    output logic                 snd_en,
    output logic [7:0]           snd_channel,
    output logic [15:0]          snd_length,
    output logic [31:0]          snd_time,
    input  logic                 snd_end,
    output logic                 busy,
    output logic                 err_timeout
);
    localparam int PW = $clog2(N_CH);
    localparam logic [PW:0]  NCH_W    = (PW+1)'(N_CH);
    localparam logic [15:0]  LEN_MAX  = 16'(MAX_LEN);
    localparam logic [15:0]  GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_END, GAP} state_t;

    state_t                   state;
    logic [PW-1:0]            ptr;
    logic [PW-1:0]            cur;
    logic [15:0]              gap_cnt;
    logic [N_CH-1:0][15:0]    len_a;
    logic [N_CH-1:0][31:0]    time_a;
    logic [PW-1:0]            pick;
    logic                     pick_vld;
    logic                     pick_bad;
    logic [15:0]              pick_len;

    assign len_a    = len_i;
    assign time_a   = time_i;
    assign pick_len = len_a[pick];
    assign pick_bad = (pick_len > LEN_MAX) || (pick_len[1:0] != 2'b00);
    assign busy     = (state != IDLE);

    // Search starts one past the last served channel, wrapping at N_CH.
    always_comb begin
        logic [PW:0] idx;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= NCH_W) idx = idx - NCH_W;
            if (!pick_vld && req[idx[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[PW-1:0];
            end
        end
    end

`ifdef UDP_SCHED_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0] wdog_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= PW'(N_CH - 1);
            cur         <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            done        <= '0;
            reject      <= 1'b0;
            snd_en      <= 1'b0;
            snd_channel <= '0;
            snd_length  <= '0;
            snd_time    <= '0;
            err_timeout <= 1'b0;
`ifdef UDP_SCHED_WATCHDOG_EN
            wdog_cnt    <= '0;
`endif
        end else begin
            done        <= '0;
            reject      <= 1'b0;
            snd_en      <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        if (pick_bad) begin
                            // Refused in place: arbitration resumes next cycle.
                            done[pick] <= 1'b1;
                            reject     <= 1'b1;
                            ptr        <= pick;
                        end else begin
                            cur         <= pick;
                            grant[pick] <= 1'b1;
                            snd_channel <= {{(8-PW){1'b0}}, pick};
                            snd_length  <= pick_len;
                            snd_time    <= time_a[pick];
                            state       <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    snd_en <= 1'b1;
                    state  <= START;
                end
                START: begin
`ifdef UDP_SCHED_WATCHDOG_EN
                    wdog_cnt <= '0;
`endif
                    state <= WAIT_END;
                end
                WAIT_END: begin
                    if (snd_end) begin
                        done[cur] <= 1'b1;
                        ptr       <= cur;
                        grant     <= '0;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end
`ifdef UDP_SCHED_WATCHDOG_EN
                    else if (wdog_cnt == WDOG_LAST) begin
                        err_timeout <= 1'b1;
                        done[cur]   <= 1'b1;
                        ptr         <= cur;
                        grant       <= '0;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else begin
                        wdog_cnt <= wdog_cnt + 32'd1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: latency, fairness, reject, reset, stray end, watchdog.
module tb_udp_tx_scheduler;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [63:0]  len_i;
    logic [127:0] time_i;
    logic [3:0]   grant, done;
    logic         reject, snd_en, snd_end, busy, err_timeout;
    logic [7:0]   snd_channel;
    logic [15:0]  snd_length;
    logic [31:0]  snd_time;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    udp_tx_scheduler #(.N_CH(4), .GAP_CYCLES(12), .MAX_LEN(1464), .WDOG_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len_i(len_i), .time_i(time_i),
        .grant(grant), .done(done), .reject(reject), .snd_en(snd_en),
        .snd_channel(snd_channel), .snd_length(snd_length), .snd_time(snd_time),
        .snd_end(snd_end), .busy(busy), .err_timeout(err_timeout)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; snd_end = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; snd_end = 1'b0;
        step(2);
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (done !== 4'b0) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
        total++; if ({reject, snd_en, busy, err_timeout} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {reject, snd_en, busy, err_timeout}); end
        total++; if ({snd_channel, snd_length, snd_time} !== 56'h0) begin bad++; $display("FAIL reset_snd got=%h want=0", {snd_channel, snd_length, snd_time}); end
        req = '0; rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        do_reset();
        len_i[15:0] = 16'd40; time_i[31:0] = 32'h12345678; req = 4'b0001;
        step(1);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", grant); end
        total++; if (snd_en !== 1'b0) begin bad++; $display("FAIL single_en_early got=%b want=0", snd_en); end
        total++; if (snd_length !== 16'd40) begin bad++; $display("FAIL single_len got=%0d want=40", snd_length); end
        total++; if (snd_channel !== 8'd0) begin bad++; $display("FAIL single_chan got=%0d want=0", snd_channel); end
        total++; if (snd_time !== 32'h12345678) begin bad++; $display("FAIL single_time got=%h want=12345678", snd_time); end
        step(1);
        total++; if (snd_en !== 1'b1) begin bad++; $display("FAIL single_en got=%b want=1", snd_en); end
        step(1);
        total++; if (snd_en !== 1'b0) begin bad++; $display("FAIL single_en_pulse got=%b want=0", snd_en); end
        step(17);
        total++; if ({grant, snd_length} !== {4'b0001, 16'd40}) begin bad++; $display("FAIL single_hold got=%h want=10028", {grant, snd_length}); end
        snd_end = 1'b1; step(1); snd_end = 1'b0;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b want=0001", done); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_grant_drop got=%b want=0000", grant); end
        req = '0;
        step(11);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap_busy got=%b want=1", busy); end
        step(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
    endtask

    task automatic test_fairness();
        int n, en_cnt;
        logic [3:0] exp_g;
        do_reset();
        for (int k = 0; k < 4; k++) len_i[16*k +: 16] = 16'(8*(k+1));
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_g = 4'b0001 << (f % 4);
            n = 0;
            while (grant == 4'b0 && n < 50) begin step(1); n++; end
            total++; if (grant !== exp_g) begin bad++; $display("FAIL fair_grant%0d got=%b want=%b", f, grant, exp_g); end
            total++; if (snd_length !== 16'(8*((f%4)+1))) begin bad++; $display("FAIL fair_len%0d got=%0d want=%0d", f, snd_length, 8*((f%4)+1)); end
            en_cnt = 0;
            repeat (4) begin step(1); en_cnt += int'(snd_en); end
            snd_end = 1'b1; step(1); snd_end = 1'b0;
            total++; if (done !== exp_g) begin bad++; $display("FAIL fair_done%0d got=%b want=%b", f, done, exp_g); end
            total++; if (en_cnt !== 1) begin bad++; $display("FAIL fair_en%0d got=%0d want=1", f, en_cnt); end
        end
        req = '0;
        step(14);
    endtask

    task automatic test_reject();
        do_reset();
        len_i[47:32] = 16'd1468; req = 4'b0100;
        step(1);
        total++; if ({done, reject} !== 5'b01001) begin bad++; $display("FAIL rej_big got=%b want=01001", {done, reject}); end
        total++; if ({grant, busy} !== 5'b0) begin bad++; $display("FAIL rej_big_nogrant got=%b want=00000", {grant, busy}); end
        req = '0;
        step(1);
        total++; if ({done, reject} !== 5'b0) begin bad++; $display("FAIL rej_pulse got=%b want=00000", {done, reject}); end
        len_i[47:32] = 16'd42; req = 4'b0100;
        step(1);
        total++; if ({done, reject, grant} !== 9'b010010000) begin bad++; $display("FAIL rej_align got=%b want=010010000", {done, reject, grant}); end
        req = '0;
        step(3);
        total++; if ({snd_en, grant, busy} !== 6'b0) begin bad++; $display("FAIL rej_nosend got=%b want=000000", {snd_en, grant, busy}); end
        len_i[47:32] = 16'd1464; req = 4'b0100;
        step(1);
        total++; if ({grant, reject, done} !== 9'b010000000) begin bad++; $display("FAIL rej_maxlen_ok got=%b want=010000000", {grant, reject, done}); end
        total++; if (snd_length !== 16'd1464) begin bad++; $display("FAIL rej_maxlen_len got=%0d want=1464", snd_length); end
        step(3);
        snd_end = 1'b1; step(1); snd_end = 1'b0; req = '0;
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL rej_maxlen_done got=%b want=0100", done); end
        step(13);
    endtask

    task automatic test_reset_mid();
        do_reset();
        len_i = {16'd16, 16'd16, 16'd16, 16'd16};
        req = 4'b0010;
        step(1);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL mid_grant got=%b want=0010", grant); end
        step(3);
        rst_n = 1'b0;
        step(1);
        total++; if ({grant, done, reject, snd_en, busy, err_timeout} !== 12'b0) begin bad++; $display("FAIL mid_flags got=%b want=0", {grant, done, reject, snd_en, busy, err_timeout}); end
        total++; if ({snd_channel, snd_length, snd_time} !== 56'h0) begin bad++; $display("FAIL mid_snd got=%h want=0", {snd_channel, snd_length, snd_time}); end
        rst_n = 1'b1; req = 4'b0011;
        step(1);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_first got=%b want=0001", grant); end
        step(3);
        snd_end = 1'b1; step(1); snd_end = 1'b0; req = '0;
        step(13);
    endtask

    task automatic test_stray();
        snd_end = 1'b1; step(1); snd_end = 1'b0;
        total++; if ({done, busy, grant} !== 9'b0) begin bad++; $display("FAIL stray_idle got=%b want=0", {done, busy, grant}); end
        req = 4'b0001;
        step(1);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL stray_grant got=%b want=0001", grant); end
        step(3);
        snd_end = 1'b1; step(1); snd_end = 1'b0; req = '0;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL stray_done got=%b want=0001", done); end
        step(1);
        snd_end = 1'b1; step(1); snd_end = 1'b0;
        total++; if ({done, busy} !== 5'b00001) begin bad++; $display("FAIL stray_gap got=%b want=00001", {done, busy}); end
        step(9);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stray_gap_len got=%b want=1", busy); end
        step(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_gap_end got=%b want=0", busy); end
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 4'b0001;
        step(1);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wd_grant got=%b want=0001", grant); end
`ifdef UDP_SCHED_WATCHDOG_EN
        step(65);
        total++; if ({err_timeout, grant} !== 5'b00001) begin bad++; $display("FAIL wd_early got=%b want=00001", {err_timeout, grant}); end
        step(1);
        total++; if ({err_timeout, done, grant, busy} !== 10'b1000100001) begin bad++; $display("FAIL wd_fire got=%b want=1000100001", {err_timeout, done, grant, busy}); end
        req = '0;
        step(1);
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_pulse got=%b want=0", err_timeout); end
`else
        step(100);
        total++; if ({busy, grant, err_timeout} !== 6'b100010) begin bad++; $display("FAIL wd_off got=%b want=100010", {busy, grant, err_timeout}); end
`endif
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; snd_end = 1'b0;
        len_i = '0; time_i = '0;
        test_reset();
        test_single();
        test_fairness();
        test_reject();
        test_reset_mid();
        test_stray();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
